// File: rtl/zrl_pkg.sv
// Shared constants, state encoding and word helpers for the zero-run-length decoder.
package zrl_pkg;

   localparam int DATA_W    = 32;
   localparam int RUN_LEN_W = 16;

   localparam logic TOK_LITERAL = 1'b0;
   localparam logic TOK_RUN     = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } zrl_state_t;

   // 32-bit zero detector shared across the codebase.
   function automatic logic is_zero32(input logic [31:0] word);
      return (word == 32'd0);
   endfunction

endpackage

// File: rtl/zrl_run_counter.sv
// Remaining-zeros counter for a run: load, saturating decrement, and is-last flag.
module zrl_run_counter
   import zrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [RUN_LEN_W-1:0] load_val,
   input  logic                 dec,
   output logic                 is_last
);

   logic [RUN_LEN_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - RUN_LEN_W'(1);
      end
   end

   // One word left means the word being loaded now is the final zero of the run.
   assign is_last = (count == RUN_LEN_W'(1));

endmodule

// File: rtl/zrl_decode32.sv
// Zero-run-length token decoder: literal and zero-run tokens in, 32-bit words out.
// Optional macro ZRL_DECODE_STATS_EN adds the zero_words statistics counter output.
module zrl_decode32
   import zrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_is_run,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
`ifdef ZRL_DECODE_STATS_EN
   output logic [31:0]       zero_words,
`endif
   output zrl_state_t        state_dbg
);

   // Handshake: a word/token moves only in a cycle where valid and ready are both high;
   // out_valid, once set, holds with stable out_data/out_last until out_ready takes it.

   zrl_state_t           state;
   logic                 last_q;
   logic [RUN_LEN_W-1:0] run_len;
   logic                 in_fire;
   logic                 out_fire;
   logic                 cnt_load;
   logic                 cnt_dec;
   logic                 cnt_is_last;

   assign run_len   = in_data[RUN_LEN_W-1:0];
   assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign cnt_load  = in_fire && (in_is_run == TOK_RUN) && (run_len >= RUN_LEN_W'(2));
   assign cnt_dec   = (state == ST_RUN) && out_fire;
   assign state_dbg = state;

   zrl_run_counter u_run_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (run_len - RUN_LEN_W'(1)),
      .dec      (cnt_dec),
      .is_last  (cnt_is_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         last_q    <= 1'b0;
      end else if (in_fire) begin
         if (in_is_run == TOK_LITERAL) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
         end else if (run_len == '0) begin
            // Empty run: nothing to emit; any held word was just taken.
            out_valid <= 1'b0;
         end else begin
            out_valid <= 1'b1;
            out_data  <= '0;
            if (run_len == RUN_LEN_W'(1)) begin
               out_last <= in_last;
            end else begin
               out_last <= 1'b0;
               last_q   <= in_last;
               state    <= ST_RUN;
            end
         end
      end else if (cnt_dec) begin
         out_valid <= 1'b1;
         out_data  <= '0;
         if (cnt_is_last) begin
            out_last <= last_q;
            last_q   <= 1'b0;
            state    <= ST_IDLE;
         end else begin
            out_last <= 1'b0;
         end
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

`ifdef ZRL_DECODE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_words <= '0;
      end else if (out_fire && is_zero32(out_data) && (zero_words != '1)) begin
         zero_words <= zero_words + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_zrl_decode32.sv
// Directed self-checking bench for zrl_decode32 with a transfer log and expected queue.
module tb_zrl_decode32;
   import zrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_is_run = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_last;
   zrl_state_t  state_dbg;
`ifdef ZRL_DECODE_STATS_EN
   logic [31:0] zero_words;
`endif

   zrl_decode32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_is_run (in_is_run),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
`ifdef ZRL_DECODE_STATS_EN
      .zero_words(zero_words),
`endif
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int low_cnt = 0;
   bit low_en  = 1'b0;

   logic [32:0] got_q[$];
   int          got_cyc[$];
   logic [32:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: record each transfer {last, data} with its cycle number.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         got_q.push_back({out_last, out_data});
         got_cyc.push_back(cyc);
      end
      if (!low_en) low_cnt <= 0;
      else if (rst_n && !in_ready) low_cnt <= low_cnt + 1;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_xfers(input string tag);
      check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask

   task automatic check_consecutive(input string tag, input int first_cyc);
      for (int i = 0; i < got_cyc.size(); i++)
         check($sformatf("%s_cyc%0d", tag, i), 64'(got_cyc[i]), 64'(first_cyc + i));
   endtask

   // ---------------- drivers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic is_run, input logic [31:0] data, input logic last,
                       input int budget, output int acc_cyc);
      bit done = 1'b0;
      in_valid  = 1'b1;
      in_is_run = is_run;
      in_data   = data;
      in_last   = last;
      for (int i = 0; i < budget && !done; i++) begin
         done = in_ready;
         tick(1);
      end
      acc_cyc   = cyc;
      in_valid  = 1'b0;
      in_is_run = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      if (!done) check("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain(input int budget);
      int i = 0;
      while (out_valid && i < budget) begin
         tick(1);
         i++;
      end
      if (out_valid) check("drain_timeout", 64'd0, 64'd1);
   endtask

   task automatic start_low_count();
      low_en = 1'b0;
      tick(1);
      low_en = 1'b1;
   endtask

   // Global time bound; a hang is reported and ends the run.
   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int acc_a, acc_b, acc_c;

      tick(3);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_out_last",  64'(out_last),  64'd0);
      check("rst_state",     64'(state_dbg), 64'(ST_IDLE));
      check("rst_in_ready",  64'(in_ready),  64'd1);
      rst_n = 1'b1;
      tick(1);

      // Single literal, continuous out_ready.
      out_ready = 1'b1;
      start_low_count();
      send(1'b0, 32'hDEADBEEF, 1'b0, 200, acc_a);
      tick(4);
      check("lit_in_ready_low", 64'(low_cnt), 64'd0);
      check("lit_latency", 64'(got_cyc.size() > 0 ? got_cyc[0] : -1), 64'(acc_a));
      exp_q.push_back({1'b0, 32'hDEADBEEF});
      check_xfers("lit");

      // Run of 4 ending a block.
      start_low_count();
      send(1'b1, 32'd4, 1'b1, 200, acc_a);
      tick(8);
      check("run4_in_ready_low", 64'(low_cnt), 64'd3);
      check_consecutive("run4", acc_a);
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b1, 32'h0});
      check_xfers("run4");
      low_en = 1'b0;

      // Empty run (with a dropped last) followed by a literal.
      send(1'b1, 32'd0, 1'b1, 200, acc_a);
      send(1'b0, 32'h00000005, 1'b0, 200, acc_b);
      tick(3);
      check("run0_no_bubble", 64'(acc_b), 64'(acc_a + 1));
      check("run0_latency", 64'(got_cyc.size() > 0 ? got_cyc[0] : -1), 64'(acc_b));
      exp_q.push_back({1'b0, 32'h00000005});
      check_xfers("run0");

      // N=1 with last, then N=2 (upper bits ignored), then a literal: no bubbles.
      send(1'b1, 32'd1, 1'b1, 200, acc_a);
      send(1'b1, 32'hABCD0002, 1'b0, 200, acc_b);
      send(1'b0, 32'h00000009, 1'b1, 200, acc_c);
      tick(4);
      check("b2b_run1_run2", 64'(acc_b), 64'(acc_a + 1));
      check("b2b_run2_lit", 64'(acc_c), 64'(acc_b + 2));
      check_consecutive("b2b", acc_a);
      exp_q.push_back({1'b1, 32'h0});
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b1, 32'h00000009});
      check_xfers("b2b");

      // Run of 3 with out_ready pattern 1,0,0,1,1.
      send(1'b1, 32'd3, 1'b0, 200, acc_a);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      tick(1);
      check("stall_valid1", 64'(out_valid), 64'd1);
      check("stall_data1",  64'(out_data),  64'd0);
      tick(1);
      check("stall_valid2", 64'(out_valid), 64'd1);
      check("stall_state",  64'(state_dbg), 64'(ST_RUN));
      out_ready = 1'b1;
      tick(2);
      tick(3);
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'h0});
      check_xfers("stall_run3");

      // Literal held under backpressure blocks the next token.
      out_ready = 1'b0;
      send(1'b0, 32'hA5A55A5A, 1'b0, 200, acc_a);
      tick(3);
      check("bp_valid",    64'(out_valid), 64'd1);
      check("bp_data",     64'(out_data),  64'hA5A55A5A);
      check("bp_in_ready", 64'(in_ready),  64'd0);
      out_ready = 1'b1;
      tick(3);
      exp_q.push_back({1'b0, 32'hA5A55A5A});
      check_xfers("bp");

      // Reset in the middle of a long run.
      send(1'b1, 32'd100, 1'b1, 200, acc_a);
      tick(10);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_state", 64'(state_dbg), 64'(ST_IDLE));
      check("mid_rst_last",  64'(out_last),  64'd0);
      got_q.delete();
      got_cyc.delete();
      tick(2);
      rst_n = 1'b1;
      tick(5);
      check("post_rst_quiet", 64'(got_q.size()), 64'd0);
      send(1'b0, 32'h00000001, 1'b0, 200, acc_a);
      tick(3);
      exp_q.push_back({1'b0, 32'h00000001});
      check_xfers("post_rst");

`ifdef ZRL_DECODE_STATS_EN
      rst_n = 1'b0;
      tick(2);
      check("stats_rst", 64'(zero_words), 64'd0);
      rst_n = 1'b1;
      tick(1);
      send(1'b0, 32'h0, 1'b0, 200, acc_a);
      send(1'b1, 32'd65535, 1'b0, 200, acc_b);
      send(1'b0, 32'h7, 1'b0, 70000, acc_c);
      drain(100);
      check("stats_zero_words", 64'(zero_words), 64'd65536);
      check("stats_xfers", 64'(got_q.size()), 64'd65537);
      got_q.delete();
      got_cyc.delete();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/zrl_decode32.md
ZRL_DECODE32 -- requirements
Module: zrl_decode32

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 in_valid  in  1  input token valid.
REQ-004 in_ready  out  1  decoder accepts token this cycle.
REQ-005 in_is_run  in  1  token type: 0 = literal word, 1 = zero-run count.
REQ-006 in_data  in  32  literal word, or run length in bits [15:0] (bits [31:16] ignored on run tokens).
REQ-007 in_last  in  1  token ends a tensor/block.
REQ-008 out_valid  out  1  output word valid.
REQ-009 out_ready  in  1  downstream accepts word.
REQ-010 out_data  out  32  decoded word.
REQ-011 out_last  out  1  final word of a token marked in_last.

Function
REQ-012 Transfer on either side occurs only when valid and ready are both high in the same cycle.
REQ-013 Single output register; out_data, out_last, out_valid are registered; out_valid stays high with data stable until accepted.
REQ-014 States: IDLE (accepting tokens) and RUN (emitting zeros); no other states.
REQ-015 in_ready = (state == IDLE) and (out_valid == 0 or out_ready == 1); it is a combinational output.
REQ-016 Literal accepted in IDLE: out_data = in_data, out_valid = 1, out_last = in_last on the next edge (latency 1); state stays IDLE.
REQ-017 Run accepted with N = 0: token consumed, no word emitted, out_valid cleared if the held word was accepted; in_last on an N = 0 token is dropped.
REQ-018 Run accepted with N = 1: one zero word loaded next edge, out_last = in_last, state stays IDLE.
REQ-019 Run accepted with N >= 2: first zero word loaded next edge, remaining count = N-1, last flag latched, state -> RUN.
REQ-020 In RUN, each output acceptance loads the next zero word and decrements the count.
REQ-021 When the final zero word is loaded: out_last = latched flag, state -> IDLE.
REQ-022 Maximum run is 65535; the count is 16 bits unsigned and never wraps below zero.
REQ-023 Throughput is one word per cycle under continuous out_ready, including the RUN -> IDLE boundary and back-to-back literals.
REQ-024 out_valid drops only when a word is accepted and no new word is loaded in the same cycle.

Reset
REQ-025 rst_n low immediately forces state = IDLE, count = 0, out_valid = 0, out_data = 0, out_last = 0, latched last = 0.
REQ-026 Reset during RUN aborts the run; remaining zeros are discarded, with no output after release until a new token.

Configuration
REQ-027 Macro ZRL_DECODE_STATS_EN adds output zero_words (out, 32) that counts accepted output words equal to zero, saturating at 0xFFFFFFFF and reset to 0.
REQ-028 Without ZRL_DECODE_STATS_EN the port and counter are absent; all other behaviour is identical.

Structure
REQ-029 Shared package/header zrl_pkg holds the state encodings (IDLE = 0, RUN = 1), RUN_LEN_W = 16, DATA_W = 32, and the token-type constants.
REQ-030 Sub-module zrl_run_counter holds the 16-bit load/decrement counter and its is-last flag; the zero-compare reuses the codebase's existing 32-bit zero detector.

Verification
REQ-031 Literal 0xDEADBEEF, out_ready = 1 -> one word 0xDEADBEEF one cycle later; in_ready is never low.
REQ-032 Run N = 4 with in_last = 1, out_ready = 1 -> four zero words on consecutive cycles with out_last only on the 4th; in_ready is low for 3 cycles.
REQ-033 Run N = 0, then literal 0x00000005 -> only 0x00000005 is emitted, with no bubble or extra word.
REQ-034 Run N = 3 with out_ready toggling 1,0,0,1,1 -> data held stable while stalled and exactly 3 zeros delivered.
REQ-035 Assert rst_n low mid-way through a run N = 100 -> out_valid = 0 at once; after release, literal 0x1 produces only 0x1.
REQ-036 With ZRL_DECODE_STATS_EN: literal 0, run N = 65535, then literal 7 -> zero_words = 65536.
